// File: rtl/nn_training_sequencer.sv
// Sample-RAM feeder and epoch controller for neural_network; outputs are registered and track the state 1:1.
// No backpressure: fixed cadence, writes ignored while busy. Optional SHUFFLE_EN XORs read addresses with an LFSR key.
module nn_training_sequencer #(
  parameter int DATA_W       = 16,
  parameter int N_IN         = 2,
  parameter int DEPTH        = 2048,
  parameter int ADDR_W       = 11,
  parameter int HOLD_CYCLES  = 10,
  parameter int RESET_CYCLES = 10,
  parameter int DRAIN_CYCLES = 200
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [N_IN*DATA_W-1:0] wr_x,
  input  logic [DATA_W-1:0]      wr_y,
  input  logic [ADDR_W:0]        num_samples,
  input  logic [15:0]            num_epochs,
  input  logic                   start,
  input  logic                   abort,
  output logic                   nn_reset,
  output logic                   block_reset_on_mux,
  output logic                   load_inital_parameters,
  output logic                   input_select,
  output logic                   en_forward,
  output logic                   en_backward,
  output logic [N_IN*DATA_W-1:0] a1_out,
  output logic [DATA_W-1:0]      y_out,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            epoch_cnt,
  output logic [ADDR_W-1:0]      sample_idx
);

  localparam int ROW_W = N_IN*DATA_W + DATA_W;
  localparam logic [ADDR_W:0] DEPTH_V    = (ADDR_W+1)'(DEPTH);
  localparam logic [15:0]     HOLD_LAST  = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0]     RST_LAST   = 16'(RESET_CYCLES - 1);
  localparam logic [15:0]     DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT_RST, S_LOAD1, S_LOAD2, S_STREAM, S_DRAIN, S_EPOCH_RST, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [15:0]       ne_q, ne_d;
  logic [15:0]       epoch_q, epoch_d;
  logic              nnr_q, nnr_d, blk_q, blk_d, load_q, load_d;
  logic              insel_q, insel_d, en_q, en_d, busy_q, busy_d, done_q, done_d;
  logic [ROW_W-1:0]  rd_dat_q;
  logic              rd_en, done_pulse, abort_hit;
  logic [ADDR_W-1:0] rd_idx, rd_addr;
  logic [ADDR_W:0]   ns_clamp;
  logic [15:0]       epoch_inc;
  logic [ROW_W-1:0]  mem [DEPTH];

  assign ns_clamp  = (num_samples > DEPTH_V) ? DEPTH_V : num_samples;
  assign epoch_inc = (epoch_q == 16'hFFFF) ? epoch_q : epoch_q + 16'd1;
  assign abort_hit = abort && (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    idx_d      = idx_q;
    last_d     = last_q;
    ne_d       = ne_q;
    epoch_d    = epoch_q;
    rd_en      = 1'b0;
    rd_idx     = idx_q + 1'b1;
    done_pulse = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (start) begin
          if (num_samples == '0 || num_epochs == 16'd0) begin
            done_pulse = 1'b1;
          end else begin
            state_d = S_INIT_RST;
            last_d  = ADDR_W'(ns_clamp - 1'b1);
            ne_d    = num_epochs;
            epoch_d = 16'd0;
            idx_d   = '0;
          end
        end
      end
      S_INIT_RST: if (cnt_q == RST_LAST) begin
        state_d = S_LOAD1;
        cnt_d   = 16'd0;
      end
      S_LOAD1: state_d = S_LOAD2;
      S_LOAD2: begin
        state_d = S_STREAM;
        cnt_d   = 16'd0;
        rd_en   = 1'b1;
        rd_idx  = '0;
      end
      S_STREAM: if (cnt_q == HOLD_LAST) begin
        cnt_d = 16'd0;
        if (idx_q == last_q) begin
          state_d = S_DRAIN;
        end else begin
          // prefetch the next sample so the RAM latency hides inside this window
          idx_d = idx_q + 1'b1;
          rd_en = 1'b1;
        end
      end
      S_DRAIN: if (cnt_q == DRAIN_LAST) begin
        cnt_d   = 16'd0;
        epoch_d = epoch_inc;
        state_d = (epoch_inc == ne_q) ? S_DONE : S_EPOCH_RST;
      end
      S_EPOCH_RST: if (cnt_q == RST_LAST) begin
        cnt_d   = 16'd0;
        state_d = S_STREAM;
        idx_d   = '0;
        rd_en   = 1'b1;
        rd_idx  = '0;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) begin
      state_d = S_IDLE;
      cnt_d   = 16'd0;
      idx_d   = idx_q;
      epoch_d = epoch_q;
      rd_en   = 1'b0;
    end
  end

  // Control outputs are a function of the state being entered, so they change on the same edge as state_q.
  always_comb begin
    nnr_d   = 1'b1;
    blk_d   = 1'b1;
    insel_d = insel_q;
    en_d    = 1'b0;
    case (state_d)
      S_IDLE:      begin nnr_d = abort_hit ? 1'b0 : nnr_q; blk_d = blk_q; end
      S_INIT_RST:  begin nnr_d = 1'b0; blk_d = 1'b0; insel_d = 1'b0; end
      S_EPOCH_RST: begin nnr_d = 1'b0; blk_d = blk_q; en_d = en_q; end
      S_STREAM:    begin en_d = 1'b1; if (state_q == S_EPOCH_RST) insel_d = 1'b1; end
      S_DRAIN:     en_d = 1'b1;
      default:     ;
    endcase
    load_d = (state_d == S_LOAD1);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE) || done_pulse;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= '0;
      last_q  <= '0;
      ne_q    <= 16'd0;
      epoch_q <= 16'd0;
      nnr_q   <= 1'b0;
      blk_q   <= 1'b0;
      load_q  <= 1'b0;
      insel_q <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      ne_q    <= ne_d;
      epoch_q <= epoch_d;
      nnr_q   <= nnr_d;
      blk_q   <= blk_d;
      load_q  <= load_d;
      insel_q <= insel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SHUFFLE_EN
  logic [15:0] lfsr_q;
  logic        full_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 16'hACE1;
      full_q <= 1'b0;
    end else if (state_q == S_IDLE && state_d == S_INIT_RST) begin
      lfsr_q <= 16'hACE1;
      full_q <= (ns_clamp == DEPTH_V);
    end else if (state_q == S_DRAIN && state_d == S_EPOCH_RST) begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  // XOR is only a permutation when the whole RAM is in use
  always_comb rd_addr = full_q ? (rd_idx ^ lfsr_q[ADDR_W-1:0]) : rd_idx;
`else
  always_comb rd_addr = rd_idx;
`endif

  always_ff @(posedge clk) begin
    if (wr_en && !busy_q) mem[wr_addr] <= {wr_y, wr_x};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rd_dat_q <= '0;
    else if (rd_en) rd_dat_q <= mem[rd_addr];
  end

  assign nn_reset               = nnr_q;
  assign block_reset_on_mux     = blk_q;
  assign load_inital_parameters = load_q;
  assign input_select           = insel_q;
  assign en_forward             = en_q;
  assign en_backward            = en_q;
  assign a1_out                 = rd_dat_q[N_IN*DATA_W-1:0];
  assign y_out                  = rd_dat_q[ROW_W-1 -: DATA_W];
  assign busy                   = busy_q;
  assign done                   = done_q;
  assign epoch_cnt              = epoch_q;
  assign sample_idx             = idx_q;

endmodule

// File: tb/tb_nn_training_sequencer.sv
// Bench for nn_training_sequencer: per-cycle expected trace built from the run description, plus abort/reset sequences.
module tb_nn_training_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [31:0] wr_x;
  logic [15:0] wr_y;
  logic [11:0] num_samples;
  logic [15:0] num_epochs;
  logic        start, abort;
  logic        nn_reset, block_reset_on_mux, load_inital_parameters, input_select;
  logic        en_forward, en_backward, busy, done;
  logic [31:0] a1_out;
  logic [15:0] y_out, epoch_cnt;
  logic [10:0] sample_idx;

  nn_training_sequencer dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
    .num_samples(num_samples), .num_epochs(num_epochs), .start(start), .abort(abort),
    .nn_reset(nn_reset), .block_reset_on_mux(block_reset_on_mux),
    .load_inital_parameters(load_inital_parameters), .input_select(input_select),
    .en_forward(en_forward), .en_backward(en_backward), .a1_out(a1_out), .y_out(y_out),
    .busy(busy), .done(done), .epoch_cnt(epoch_cnt), .sample_idx(sample_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        nnr, blk, ld, isel, en, bsy, dn;
    logic [15:0] ep;
    logic        chk;
    logic [10:0] idx;
    logic [31:0] a1;
    logic [15:0] y;
  } exp_t;

  typedef struct {
    int ns, ne, exp_busy, exp_done, exp_epoch;
  } row_t;

  exp_t        sb_q[$];
  row_t        rows[7];
  logic [15:0] mx0[2048], mx1[2048], my[2048];
  int          checks = 0, errors = 0, cyc = 0;
  logic        m_nnr = 1'b0, m_blk = 1'b0, m_isel = 1'b0;
  logic [15:0] m_ep = 16'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
    end
  endtask

  task automatic push_rec(input logic nnr, blk, ld, isel, en, bsy, dn, input logic [15:0] ep,
                          input logic chk, input int k);
    exp_t r;
    r.nnr = nnr; r.blk = blk; r.ld = ld; r.isel = isel; r.en = en; r.bsy = bsy; r.dn = dn;
    r.ep = ep; r.chk = chk; r.idx = 11'(k); r.a1 = {mx1[k], mx0[k]}; r.y = my[k];
    sb_q.push_back(r);
  endtask

  task automatic model_run(input int ns, input int ne);
    int n;
    n = (ns > 2048) ? 2048 : ns;
    if (n == 0 || ne == 0) begin
      push_rec(m_nnr, m_blk, 0, m_isel, 0, 0, 1, m_ep, 0, 0);
      push_rec(m_nnr, m_blk, 0, m_isel, 0, 0, 0, m_ep, 0, 0);
      return;
    end
    repeat (10) push_rec(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    push_rec(1, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    push_rec(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int e = 1; e <= ne; e++) begin
      for (int k = 0; k < n; k++)
        repeat (10) push_rec(1, 1, 0, e > 1, 1, 1, 0, 16'(e - 1), 1, k);
      repeat (200) push_rec(1, 1, 0, e > 1, 1, 1, 0, 16'(e - 1), 1, n - 1);
      if (e < ne) repeat (10) push_rec(0, 1, 0, e > 1, 1, 1, 0, 16'(e), 0, 0);
    end
    push_rec(1, 1, 0, ne > 1, 0, 0, 1, 16'(ne), 1, n - 1);
    push_rec(1, 1, 0, ne > 1, 0, 0, 0, 16'(ne), 1, n - 1);
    m_nnr = 1'b1; m_blk = 1'b1; m_isel = (ne > 1); m_ep = 16'(ne);
  endtask

  task automatic run_row(input int ns, input int ne, input int exp_busy, input int exp_done,
                         input int exp_epoch);
    exp_t r;
    int   nb, nd;
    nb = 0; nd = 0;
    model_run(ns, ne);
    num_samples = 12'(ns);
    num_epochs  = 16'(ne);
    start = 1'b1;
    while (sb_q.size() > 0) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      r = sb_q.pop_front();
      check("ctl", 64'({nn_reset, block_reset_on_mux, load_inital_parameters, input_select,
                        en_forward, en_backward, busy, done, epoch_cnt}),
                   64'({r.nnr, r.blk, r.ld, r.isel, r.en, r.en, r.bsy, r.dn, r.ep}));
      if (r.chk) check("dat", {5'd0, sample_idx, y_out, a1_out}, {5'd0, r.idx, r.y, r.a1});
      if (busy) nb++;
      if (done) nd++;
    end
    check("busy_cycles", 64'(nb), 64'(exp_busy));
    check("done_pulses", 64'(nd), 64'(exp_done));
    check("epoch_final", 64'(epoch_cnt), 64'(exp_epoch));
  endtask

  task automatic wait_sample1();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(posedge clk); #1;
      cyc++;
      if (en_forward && sample_idx == 11'd1) ok = 1'b1;
    end
    check("reach_sample1", 64'(ok), 64'd1);
  endtask

  function automatic logic [63:0] all_out();
    return {nn_reset, block_reset_on_mux, load_inital_parameters, input_select, en_forward,
            en_backward, busy, done, epoch_cnt, sample_idx, y_out} | 64'(a1_out);
  endfunction

  initial begin
    rows[0] = '{2, 1, 232, 1, 1};
    rows[1] = '{2, 3, 692, 1, 3};
    rows[2] = '{0, 5, 0, 1, 3};
    rows[3] = '{3, 0, 0, 1, 3};
    rows[4] = '{1, 2, 442, 1, 2};
    rows[5] = '{3, 1, 242, 1, 1};
    rows[6] = '{4095, 1, 20692, 1, 1};
    for (int i = 0; i < 2048; i++) begin
      mx0[i] = 16'(i * 7 - 3000);
      mx1[i] = 16'(2000 - i * 5);
      my[i]  = 16'(i * 3 + 1);
    end
    mx0[0] = 16'(-4750); mx1[0] = 16'(1013);  my[0] = 16'(4096);
    mx0[1] = 16'(250);   mx1[1] = 16'(-1555); my[1] = 16'(4096);
    mx0[2] = 16'(7);     mx1[2] = 16'(-8);    my[2] = 16'(-4096);

    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_y = '0;
    num_samples = '0; num_epochs = '0; start = 1'b0; abort = 1'b0;
    #3;
    check("reset_state", all_out(), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 2048; i++) begin
      wr_en = 1'b1; wr_addr = 11'(i); wr_x = {mx1[i], mx0[i]}; wr_y = my[i];
      @(posedge clk); #1;
    end
    wr_en = 1'b0;

    for (int i = 0; i < 7; i++)
      run_row(rows[i].ns, rows[i].ne, rows[i].exp_busy, rows[i].exp_done, rows[i].exp_epoch);

    // abort on the 5th cycle of sample 1
    num_samples = 12'd2; num_epochs = 16'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_sample1();
    repeat (4) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_outputs", 64'({en_forward, en_backward, nn_reset, busy, done, load_inital_parameters}), 64'd0);
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      check("abort_no_done", 64'({busy, done}), 64'd0);
    end
    m_nnr = 1'b0; m_blk = 1'b1; m_isel = 1'b0; m_ep = 16'd0;
    run_row(2, 1, 232, 1, 1);

    // write while busy, then async reset mid-stream
    num_samples = 12'd3; num_epochs = 16'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_sample1();
    wr_en = 1'b1; wr_addr = 11'd0; wr_x = 32'hDEAD_BEEF; wr_y = 16'h5A5A;
    repeat (2) begin @(posedge clk); #1; end
    wr_en = 1'b0;
    #2 reset = 1'b0;
    #1 check("async_reset", all_out(), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    m_nnr = 1'b0; m_blk = 1'b0; m_isel = 1'b0; m_ep = 16'd0;
    run_row(2, 1, 232, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
